qspi_latency_line: RTL and testbench
====================================

// Module: qspi_latency_line
// PURPOSE
//  Parametrised read-data delay line for the QSPI PMOD path. Models per-device
//  return latency (flash, RAM A, RAM B) between the memory model and the SoC's
//  QSPI data inputs. Latency is runtime-programmable per chip select, captured
//  at transaction start, and carries a valid sideband so idle cycles are marked.
// PARAMETERS
//  DATA_WIDTH     4   width of QSPI data bus
//  NUM_CHANNELS   3   number of active-low chip selects (0=flash,1=RAM A,2=RAM B)
//  MAX_LATENCY    8   deepest supported delay in clk cycles (>=1)
//  RESET_LATENCY  0   per-channel latency after reset (<=MAX_LATENCY)
//  IDLE_VALUE     0   data_out value whenever valid_out is 0
//  (LW=$clog2(MAX_LATENCY+1), CW=max(1,$clog2(NUM_CHANNELS)))
// PORTS
//  clk            in   1             clock, all state on rising edge
//  rst            in   1             synchronous reset, active-high
//  sel_n          in   NUM_CHANNELS  chip selects, active-low
//  data_in        in   DATA_WIDTH    undelayed data from memory model
//  data_out       out  DATA_WIDTH    delayed data to SoC
//  valid_out      out  1             data_out belongs to a selected cycle
//  cfg_wr         in   1             write cfg_lat to channel cfg_chan
//  cfg_chan       in   CW            config channel index
//  cfg_lat        in   LW            requested latency
//  cfg_rdata      out  LW            stored latency of cfg_chan (combinational)
//  active_lat     out  LW            latency currently applied to data_out
//  err_multi_sel  out  1             sticky: >1 select low in same cycle
// BEHAVIOUR
//  - Reset (rst=1 at edge): lat_reg[*]=RESET_LATENCY, hist[*]=IDLE_VALUE,
//    vhist[*]=0, lat_q=0, prev_any=0, err=0. While rst=1 data_out=IDLE_VALUE,
//    valid_out=0, active_lat=0 regardless of inputs.
//  - any_sel = |~sel_n; chan = lowest index with sel_n low.
//  - History: every cycle hist[0]<=data_in, hist[i]<=hist[i-1];
//    vhist[0]<=any_sel, shifting alike. data_in sampled even when unselected.
//  - start = any_sel & ~prev_any (prev_any registered any_sel).
//  - eff_lat = start ? lat_reg[chan] : lat_q; on start lat_q<=lat_reg[chan].
//    lat_q held through transaction and after deselect so the tail drains;
//    reloaded only at next start (stale tail from previous latency discarded).
//  - active_lat = eff_lat.
//  - eff_lat==0: valid_out=any_sel, data_out=data_in (combinational bypass).
//    eff_lat=L>=1: valid_out=vhist[L-1], data_out=hist[L-1].
//    valid_out=0 forces data_out=IDLE_VALUE.
//  - Config: cfg_wr writes lat_reg[cfg_chan] next edge; cfg_lat>MAX_LATENCY
//    clamps to MAX_LATENCY; cfg_chan>=NUM_CHANNELS ignored. Write to an active
//    channel does not affect lat_q until the next start. cfg_wr with start in
//    same cycle: start uses old value.
//  - Multiple selects: lowest index wins; err_multi_sel set next edge, sticky
//    until rst. Select changing channel without idle cycle is not a new start.
//  - Reset mid-transaction: pipeline cleared; outputs idle the cycle after rst
//    deasserts unless a select is low (then that cycle is a start).
// TESTING
//  1 ch0 lat 0, sel_n=3'b110, data_in=4'hA -> same cycle data_out=A, valid=1.
//  2 ch1 lat 3, sel_n[1] low cycles 0-4, data 1..5 -> data_out 1..5 cycles 3-7,
//    valid high only cycles 3-7, data_out=IDLE_VALUE elsewhere.
//  3 MAX_LATENCY=8, cfg_chan=2, cfg_lat=15 -> cfg_rdata=8; cfg_chan=3 ignored.
//  4 ch0 lat 2, write 5 mid-transaction -> active_lat stays 2 to end of tail;
//    next transaction delayed by 5 cycles.
//  5 sel_n=3'b010 -> err_multi_sel=1 next cycle, ch0 latency used, stays 1
//    after sel release until rst.
//  6 rst pulse during ch2 lat 4 transfer -> valid_out=0 same cycle, no stale
//    data emitted afterwards, cfg_rdata=RESET_LATENCY for all channels.

Source files
------------

// File: rtl/qspi_latency_line_if.sv
// Bus bundle between the QSPI memory model, the latency line and the SoC
// data inputs. The master side drives selects, raw data and configuration;
// the slave side (the latency line) returns delayed data and status.
interface qspi_latency_line_if #(
    parameter int DATA_WIDTH   = 4,
    parameter int NUM_CHANNELS = 3,
    parameter int MAX_LATENCY  = 8
);
    localparam int LW = $clog2(MAX_LATENCY + 1);
    localparam int CW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

    logic [NUM_CHANNELS-1:0] sel_n;
    logic [DATA_WIDTH-1:0]   data_in;
    logic [DATA_WIDTH-1:0]   data_out;
    logic                    valid_out;
    logic                    cfg_wr;
    logic [CW-1:0]           cfg_chan;
    logic [LW-1:0]           cfg_lat;
    logic [LW-1:0]           cfg_rdata;
    logic [LW-1:0]           active_lat;
    logic                    err_multi_sel;

    modport master (
        output sel_n, data_in, cfg_wr, cfg_chan, cfg_lat,
        input  data_out, valid_out, cfg_rdata, active_lat, err_multi_sel
    );

    modport slave (
        input  sel_n, data_in, cfg_wr, cfg_chan, cfg_lat,
        output data_out, valid_out, cfg_rdata, active_lat, err_multi_sel
    );
endinterface

// File: rtl/qspi_latency_line.sv
// Read-data delay line for the QSPI PMOD path. Each chip select has its own
// programmable return latency; the latency is latched when a transaction
// starts and held until the next start so the delayed tail drains cleanly.
// A valid sideband marks which output cycles carry selected data.
module qspi_latency_line #(
    parameter int                    DATA_WIDTH    = 4,
    parameter int                    NUM_CHANNELS  = 3,
    parameter int                    MAX_LATENCY   = 8,
    parameter int                    RESET_LATENCY = 0,
    parameter logic [DATA_WIDTH-1:0] IDLE_VALUE    = '0
) (
    input  logic               clk,
    input  logic               rst,
    qspi_latency_line_if.slave bus
);
    localparam int            LW      = $clog2(MAX_LATENCY + 1);
    localparam int            CW      = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam logic [LW-1:0] MAX_LAT = LW'(MAX_LATENCY);
    localparam logic [LW-1:0] RST_LAT = LW'(RESET_LATENCY);

    // Stored per-channel latencies and the data/valid history taps.
    logic [LW-1:0]           lat_reg [NUM_CHANNELS];
    logic [DATA_WIDTH-1:0]   hist    [MAX_LATENCY];
    logic [MAX_LATENCY-1:0]  vhist;
    logic [LW-1:0]           lat_q;
    logic                    prev_any;
    logic                    err;

    logic [NUM_CHANNELS-1:0] sel_low;
    logic                    any_sel;
    logic                    multi_sel;
    logic                    start;
    logic [LW-1:0]           sel_lat;
    logic [LW-1:0]           eff_lat;
    logic [LW-1:0]           wr_lat;
    logic                    tap_valid;
    logic [DATA_WIDTH-1:0]   tap_data;

    assign sel_low   = ~bus.sel_n;
    assign any_sel   = |sel_low;
    // More than one bit set: clearing the lowest set bit leaves something.
    assign multi_sel = |(sel_low & (sel_low - NUM_CHANNELS'(1)));
    // A channel hand-over without an idle cycle is not a new start.
    assign start     = any_sel & ~prev_any;
    assign eff_lat   = start ? sel_lat : lat_q;
    assign wr_lat    = (bus.cfg_lat > MAX_LAT) ? MAX_LAT : bus.cfg_lat;

    assign bus.err_multi_sel = err;

    // Latency of the lowest-indexed selected channel (lowest index wins).
    always_comb begin
        // NOTE: give every combinational output a default before any branch,
        // otherwise an uncovered path would infer a latch.
        sel_lat = lat_reg[0];
        for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
            if (sel_low[i]) sel_lat = lat_reg[i];
        end
    end

    // Readback of the stored latency for the addressed channel.
    always_comb begin
        bus.cfg_rdata = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (bus.cfg_chan == CW'(i)) bus.cfg_rdata = lat_reg[i];
        end
    end

    // Tap selection: latency 0 bypasses the history entirely.
    always_comb begin
        tap_valid = any_sel;
        tap_data  = bus.data_in;
        for (int i = 1; i <= MAX_LATENCY; i++) begin
            if (eff_lat == LW'(i)) begin
                tap_valid = vhist[i-1];
                tap_data  = hist[i-1];
            end
        end
    end

    // Output gating: reset and invalid cycles present the idle value.
    always_comb begin
        bus.valid_out  = tap_valid & ~rst;
        bus.data_out   = bus.valid_out ? tap_data : IDLE_VALUE;
        bus.active_lat = rst ? '0 : eff_lat;
    end

    // Data and valid history shift registers, advanced every cycle.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so each stage
        // samples its neighbour's pre-edge value and the shift is race-free.
        if (rst) begin
            // NOTE: the history is a memory that is deliberately reset here;
            // a reset mid-transfer must never replay stale data afterwards.
            for (int i = 0; i < MAX_LATENCY; i++) hist[i] <= IDLE_VALUE;
            vhist <= '0;
        end else begin
            hist[0]  <= bus.data_in;
            vhist[0] <= any_sel;
            for (int i = 1; i < MAX_LATENCY; i++) begin
                hist[i]  <= hist[i-1];
                vhist[i] <= vhist[i-1];
            end
        end
    end

    // Configuration registers, transaction latency capture and error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CHANNELS; i++) lat_reg[i] <= RST_LAT;
            lat_q    <= '0;
            prev_any <= 1'b0;
            err      <= 1'b0;
        end else begin
            if (start) lat_q <= sel_lat;
            prev_any <= any_sel;
            if (multi_sel) err <= 1'b1;
            // Out-of-range channel indices match no register and are ignored.
            if (bus.cfg_wr) begin
                for (int i = 0; i < NUM_CHANNELS; i++) begin
                    if (bus.cfg_chan == CW'(i)) lat_reg[i] <= wr_lat;
                end
            end
        end
    end
endmodule

// File: tb/tb_qspi_latency_line.sv
// Scoreboard bench for qspi_latency_line. The driver applies one cycle of
// stimulus, derives the expected outputs from a cycle-indexed record of
// everything that entered the line, and queues them; the monitor pops and
// compares on the falling edge of the same cycle.
module tb_qspi_latency_line;
    localparam int              DW   = 4;
    localparam int              NC   = 3;
    localparam int              ML   = 8;
    localparam int              RL   = 0;
    localparam logic [DW-1:0]   IDLE = '0;
    localparam int              LW   = $clog2(ML + 1);
    localparam int              CW   = 2;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    qspi_latency_line_if #(.DATA_WIDTH(DW), .NUM_CHANNELS(NC), .MAX_LATENCY(ML)) bus ();

    qspi_latency_line #(
        .DATA_WIDTH(DW), .NUM_CHANNELS(NC), .MAX_LATENCY(ML),
        .RESET_LATENCY(RL), .IDLE_VALUE(IDLE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic          valid;
        logic [DW-1:0] data;
        logic [LW-1:0] act;
        bit            rd_chk;
        logic [LW-1:0] rdata;
        logic          err;
        int            cyc;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference state: what went in on each cycle, plus per-channel settings.
    bit   in_sel[$];
    int   in_dat[$];
    int   lat_m[NC];
    int   cur_lat;
    bit   prev_any_m;
    bit   err_m;
    int   last_rst = -1;
    bit   known    = 1'b0;
    int   cyc      = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
        end
    endtask

    // One cycle of stimulus plus the expected outputs for that cycle.
    task automatic step(input bit r, input logic [NC-1:0] s, input logic [DW-1:0] d,
                        input bit w, input int ch, input int wl);
        exp_t e;
        int   chan;
        int   nsel;
        int   eff;
        int   src;
        bit   any;
        bit   strt;
        @(posedge clk);
        #1;
        rst          = r;
        bus.sel_n    = s;
        bus.data_in  = d;
        bus.cfg_wr   = w;
        bus.cfg_chan = CW'(ch);
        bus.cfg_lat  = LW'(wl);

        chan = -1;
        nsel = 0;
        for (int i = 0; i < NC; i++) begin
            if (!s[i]) begin
                nsel++;
                if (chan < 0) chan = i;
            end
        end
        any  = (nsel > 0);
        strt = any && !prev_any_m;
        eff  = strt ? lat_m[chan] : cur_lat;

        e.cyc    = cyc;
        e.err    = err_m;
        e.rd_chk = (ch < NC);
        e.rdata  = (ch < NC) ? LW'(lat_m[ch]) : '0;
        if (r) begin
            e.valid = 1'b0;
            e.data  = IDLE;
            e.act   = '0;
        end else begin
            e.act = LW'(eff);
            if (eff == 0) begin
                e.valid = any;
                e.data  = any ? d : IDLE;
            end else begin
                // Data that entered eff cycles ago, unless a reset came since.
                src = cyc - eff;
                if (src >= 0 && src > last_rst) begin
                    e.valid = in_sel[src];
                    e.data  = in_sel[src] ? DW'(in_dat[src]) : IDLE;
                end else begin
                    e.valid = 1'b0;
                    e.data  = IDLE;
                end
            end
        end
        if (known) exp_q.push_back(e);

        in_sel.push_back(any);
        in_dat.push_back(int'(d));

        if (r) begin
            for (int i = 0; i < NC; i++) lat_m[i] = RL;
            cur_lat    = 0;
            prev_any_m = 1'b0;
            err_m      = 1'b0;
            last_rst   = cyc;
            known      = 1'b1;
        end else begin
            if (strt) cur_lat = lat_m[chan];
            prev_any_m = any;
            if (nsel > 1) err_m = 1'b1;
            if (w && ch < NC) lat_m[ch] = (wl > ML) ? ML : wl;
        end
        cyc++;
    endtask

    // Monitor: compare the queued expectation against the settled outputs.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check($sformatf("valid_out c%0d", e.cyc), bus.valid_out, e.valid);
                check($sformatf("data_out c%0d", e.cyc), bus.data_out, e.data);
                check($sformatf("active_lat c%0d", e.cyc), bus.active_lat, e.act);
                check($sformatf("err_multi_sel c%0d", e.cyc), bus.err_multi_sel, e.err);
                if (e.rd_chk) check($sformatf("cfg_rdata c%0d", e.cyc), bus.cfg_rdata, e.rdata);
            end
        end
    end

    initial begin
        logic [NC-1:0] cur_s;
        int            k;
        bit            rr;
        bit            ww;

        rst          = 1'b1;
        bus.sel_n    = '1;
        bus.data_in  = '0;
        bus.cfg_wr   = 1'b0;
        bus.cfg_chan = '0;
        bus.cfg_lat  = '0;
        step(1, '1, 0, 0, 0, 0);
        step(1, '1, 0, 0, 0, 0);

        // Latency 0 bypass on channel 0.
        step(0, 3'b110, 4'hA, 0, 0, 0);
        @(negedge clk);
        check("t1_data", bus.data_out, 4'hA);
        check("t1_valid", bus.valid_out, 1'b1);
        step(0, '1, 0, 0, 0, 0);

        // Channel 1 at latency 3, five data beats.
        step(0, '1, 0, 1, 1, 3);
        for (int i = 0; i < 5; i++) step(0, 3'b101, DW'(i + 1), 0, 1, 0);
        repeat (6) step(0, '1, 0, 0, 1, 0);

        // Clamp and out-of-range channel.
        step(0, '1, 0, 1, 2, 15);
        step(0, '1, 0, 0, 2, 0);
        @(negedge clk);
        check("t3_clamp", bus.cfg_rdata, 8);
        step(0, '1, 0, 1, 3, 5);
        for (int i = 0; i < NC; i++) step(0, '1, 0, 0, i, 0);

        // Channel 0 at latency 2 with a mid-transaction rewrite to 5.
        step(0, '1, 0, 1, 0, 2);
        for (int i = 0; i < 4; i++) step(0, 3'b110, DW'(i + 3), (i == 1), 0, (i == 1) ? 5 : 0);
        repeat (4) step(0, '1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 3'b110, DW'(i + 9), 0, 0, 0);
        repeat (7) step(0, '1, 0, 0, 0, 0);

        // Two selects at once: sticky error, channel 0 latency applies.
        step(0, 3'b010, 4'h7, 0, 0, 0);
        step(0, '1, 0, 0, 0, 0);
        @(negedge clk);
        check("t5_err", bus.err_multi_sel, 1'b1);
        repeat (3) step(0, '1, 0, 0, 1, 0);

        // Reset in the middle of a channel 2 latency-4 transfer.
        step(0, '1, 0, 1, 2, 4);
        for (int i = 0; i < 6; i++) begin
            step((i == 3), 3'b011, DW'(i + 8), 0, i % NC, 0);
            if (i == 3) begin
                @(negedge clk);
                check("t6_valid_in_rst", bus.valid_out, 1'b0);
            end
        end
        for (int i = 0; i < 6; i++) step(0, '1, 0, 0, i % NC, 0);

        // Randomised traffic with occasional config writes and resets.
        cur_s = '1;
        repeat (2000) begin
            if ($urandom_range(0, 99) < 15) begin
                k = $urandom_range(0, 9);
                if (k < 4)      cur_s = '1;
                else if (k < 9) cur_s = ~(NC'(1) << (k % NC));
                else            cur_s = NC'($urandom_range(0, 7));
            end
            ww = ($urandom_range(0, 7) == 0);
            rr = ($urandom_range(0, 199) == 0);
            step(rr, cur_s, DW'($urandom), ww, $urandom_range(0, 3), $urandom_range(0, 15));
        end

        // Let the monitor consume the last expectation, bounded.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        check("drain", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
